// File: rtl/dmem_if.sv
// dmem_if: request/response valid/ready handshake between the core's load/store path
// (master) and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time RV32I data-memory responder with WAIT_CYCLES wait states.
// Define DMEM_ERR_EN to report misaligned, out-of-range and illegal-funct3 requests on rsp_err.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave dmem_io
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          access, illegal, err, wr_en;
    logic [1:0]    size;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wd, word, ext;
    logic [7:0]    b_v;
    logic [15:0]   h_v;
    assign access  = state_q == WAIT && cnt_q == 4'd0;
    assign illegal = we_q ? (f3_q[2] || f3_q[1:0] == 2'b11) : (f3_q[1:0] == 2'b11 || f3_q == 3'b110);
    // 0 byte, 1 halfword, 2 word; illegal codes fall back to a word access
    assign size    = illegal ? 2'd2 : f3_q[1:0];
    assign idx     = addr_q[AW+1:2];
`ifdef DMEM_ERR_EN
    logic oor_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) oor_q <= 1'b0;
        else if (state_q == IDLE && dmem_io.req_valid) oor_q <= |dmem_io.req_addr[31:AW+2];
    end
    assign err = illegal || oor_q || (size == 2'd1 && addr_q[0]) || (size == 2'd2 && addr_q[1:0] != 2'b00);
`else
    assign err = 1'b0;
`endif
    assign wr_en = access && we_q && !err;
    assign be    = size == 2'd0 ? 4'b0001 << addr_q[1:0] : size == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd    = size == 2'd0 ? {4{wdata_q[7:0]}} : size == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    assign word  = mem[idx];
    assign b_v   = 8'(word >> {addr_q[1:0], 3'b000});
    assign h_v   = 16'(word >> {addr_q[1], 4'b0000});
    assign ext   = size == 2'd0 ? {{24{~f3_q[2] & b_v[7]}}, b_v}
                 : size == 2'd1 ? {{16{~f3_q[2] & h_v[15]}}, h_v} : word;
    // Storage is deliberately left out of reset; only control and outputs are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (dmem_io.req_valid) begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
                we_d    = dmem_io.req_we;
                addr_d  = dmem_io.req_addr[AW+1:0];
                wdata_d = dmem_io.req_wdata;
                f3_d    = dmem_io.req_funct3;
            end
            // a zero count still spends one WAIT cycle: the access edge is N+1+WAIT_CYCLES
            WAIT: if (access) begin
                state_d = RESP;
                rdata_d = (we_q || err) ? 32'd0 : ext;
                err_d   = err;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (dmem_io.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign dmem_io.req_ready = state_q == IDLE;
    assign dmem_io.rsp_valid = state_q == RESP;
    assign dmem_io.rsp_rdata = rdata_q;
    assign dmem_io.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder against a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int WT    = 2;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        in_rsp = 1'b0;
    logic        ready_chk = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    exp_t        q[$];
    exp_t        e_mon;
    logic [7:0]  rmem [4*DEPTH];
    dmem_if dif();
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WT)) dut (
        .clk(clk),
        .rst(rst),
        .dmem_io(dif)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        dif.rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, req, cyc);
        end
    endtask
    // Reference: byte-addressed little-endian memory, sizes and extension from the RV32I rules.
    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output logic e);
        bit ill;
        int n;
        int unsigned base;
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        n = ill ? 4 : (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        e = 1'b0;
`ifdef DMEM_ERR_EN
        e = ill || (a % n != 0) || (a / 4 >= DEPTH);
`endif
        base = a % (4 * DEPTH);
        base = base - base % n;
        rd = 32'd0;
        if (!e) begin
            if (we) begin
                for (int k = 0; k < n; k++) rmem[base + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) rd[8*k +: 8] = rmem[base + k];
                if (f3 < 3'd4 && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
            end
        end
    endtask
    // Called at a negedge; returns at the negedge after the request is accepted.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        exp_t x;
        int g = 0;
        dif.req_valid  = 1'b1;
        dif.req_we     = we;
        dif.req_addr   = a;
        dif.req_wdata  = wd;
        dif.req_funct3 = f3;
        while (!dif.req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!dif.req_ready) begin
            check("req_accept_timeout", 32'd0, 32'd1);
        end else begin
            model(we, a, wd, f3, x.rdata, x.err);
            x.cyc = cyc + 2 + WT;
            q.push_back(x);
            @(negedge clk);
        end
        dif.req_valid = 1'b0;
    endtask
    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || dif.rsp_valid) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) check("drain_timeout", 32'd0, 32'd1);
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_chk) begin
                check("req_ready_after_hs", 32'(dif.req_ready), 32'd1);
                ready_chk = 1'b0;
            end
            if (dif.rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    held_rdata = dif.rsp_rdata;
                    held_err = dif.rsp_err;
                    check("rsp_expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) check("latency", 32'(cyc), 32'(q[0].cyc));
                end else begin
                    check("rdata_stable", dif.rsp_rdata, held_rdata);
                    check("err_stable", 32'(dif.rsp_err), 32'(held_err));
                end
                check("req_ready_busy", 32'(dif.req_ready), 32'd0);
                if (dif.rsp_ready) begin
                    if (q.size() != 0) begin
                        e_mon = q.pop_front();
                        check("rdata", dif.rsp_rdata, e_mon.rdata);
                        check("err", 32'(dif.rsp_err), 32'(e_mon.err));
                    end
                    in_rsp = 1'b0;
                    ready_chk = 1'b1;
                end
            end
        end
    end
    initial begin
        int g;
        logic w;
        logic [31:0] a;
        dif.req_valid  = 1'b0;
        dif.req_we     = 1'b0;
        dif.req_addr   = 32'd0;
        dif.req_wdata  = 32'd0;
        dif.req_funct3 = 3'd0;
        dif.rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(dif.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(dif.rsp_valid), 32'd0);
        check("rst_rsp_rdata", dif.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(dif.rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(4 * i), $urandom, 3'd2);
        issue(1'b1, 32'h40, 32'hDEADBEEF, 3'd2);
        issue(1'b0, 32'h40, 32'd0, 3'd2);
        issue(1'b1, 32'h41, 32'h00000080, 3'd0);
        issue(1'b0, 32'h41, 32'd0, 3'd0);
        issue(1'b0, 32'h41, 32'd0, 3'd4);
        issue(1'b0, 32'h40, 32'd0, 3'd2);
        issue(1'b0, 32'h42, 32'd0, 3'd1);
        issue(1'b0, 32'h42, 32'd0, 3'd5);
        drain();
        hold = 1'b1;
        issue(1'b0, 32'h40, 32'd0, 3'd2);
        g = 0;
        while (!dif.rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("hold_rsp_seen", 32'(dif.rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        hold = 1'b0;
        issue(1'b0, 32'h42, 32'd0, 3'd2);
        issue(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 3'd2);
        issue(1'b0, 32'h0, 32'd0, 3'd2);
        issue(1'b0, 32'h40, 32'd0, 3'd2);
        drain();
        dif.req_valid  = 1'b1;
        dif.req_we     = 1'b1;
        dif.req_addr   = 32'h80;
        dif.req_wdata  = 32'h12345678;
        dif.req_funct3 = 3'd2;
        g = 0;
        while (!dif.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        dif.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(dif.req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(dif.rsp_valid), 32'd0);
        check("midrst_rsp_rdata", dif.rsp_rdata, 32'd0);
        check("midrst_rsp_err", 32'(dif.rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'h80, 32'd0, 3'd2);
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
            issue(w, a, $urandom, w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)));
        end
        drain();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
